// File: rtl/hacd_axi_rd_burst_split.sv
// AXI4 read burst splitter: long INCR bursts go downstream as MAX_BEATS-beat sub-bursts,
// and the R beats are merged back into one upstream burst carrying a single rlast.
module hacd_axi_rd_burst_split #(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 1,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic [USER_WIDTH-1:0] s_axi_ruser,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [USER_WIDTH-1:0] m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic [USER_WIDTH-1:0] m_axi_ruser,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int LOG2_MB = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  lock_q;
  logic [3:0]            cache_q;
  logic [2:0]            prot_q;
  logic [3:0]            qos_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [8:0]            rem_q, n_sub_q, iss_cnt, r_sub_cnt;
  logic                  done_q, ar_rdy_q;

  logic                  active, s_ar_hs, m_ar_hs, m_r_last_hs, fin_hs, last_ar, split;
  logic [8:0]            beats_in, rem_nxt;
  logic [ADDR_WIDTH-1:0] addr_align, step;

  assign beats_in    = {1'b0, s_axi_arlen} + 9'd1;
  assign split       = (s_axi_arburst == 2'b01) && (beats_in > 9'(MAX_BEATS));
  assign rem_nxt     = rem_q - 9'(MAX_BEATS);
  assign step        = ADDR_WIDTH'(MAX_BEATS) << size_q;
  assign addr_align  = addr_q & ~((ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1));

  assign active      = (state != IDLE);
  assign s_ar_hs     = s_axi_arvalid & ar_rdy_q;
  assign m_ar_hs     = m_axi_arvalid & m_axi_arready;
  assign last_ar     = (iss_cnt == n_sub_q - 9'd1);
  assign m_r_last_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign fin_hs      = s_axi_rvalid & s_axi_rready & s_axi_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ar_rdy_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      lock_q    <= 1'b0;
      cache_q   <= '0;
      prot_q    <= '0;
      qos_q     <= '0;
      user_q    <= '0;
      rem_q     <= '0;
      n_sub_q   <= '0;
      iss_cnt   <= '0;
      r_sub_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ar_rdy_q <= (state_nxt == IDLE);
      if (s_ar_hs) begin
        id_q      <= s_axi_arid;
        addr_q    <= s_axi_araddr;
        len_q     <= split ? 8'(MAX_BEATS - 1) : s_axi_arlen;
        size_q    <= s_axi_arsize;
        burst_q   <= s_axi_arburst;
        lock_q    <= s_axi_arlock;
        cache_q   <= s_axi_arcache;
        prot_q    <= s_axi_arprot;
        qos_q     <= s_axi_arqos;
        user_q    <= s_axi_aruser;
        rem_q     <= beats_in;
        n_sub_q   <= split ? (({1'b0, s_axi_arlen} >> LOG2_MB) + 9'd1) : 9'd1;
        iss_cnt   <= '0;
        r_sub_cnt <= '0;
        done_q    <= 1'b0;
      end else begin
        // Only the first sub-AR may be unaligned; later ones start on a size boundary.
        if (m_ar_hs) begin
          iss_cnt <= iss_cnt + 9'd1;
          rem_q   <= rem_nxt;
          addr_q  <= addr_align + step;
          len_q   <= (rem_nxt >= 9'(MAX_BEATS)) ? 8'(MAX_BEATS - 1) : 8'(rem_nxt - 9'd1);
        end
        if (m_r_last_hs) r_sub_cnt <= r_sub_cnt + 9'd1;
        if (fin_hs && state == ISSUE) done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_ar_hs) state_nxt = ISSUE;
      ISSUE:   if (m_ar_hs && last_ar) state_nxt = (done_q || fin_hs) ? IDLE : DRAIN;
      DRAIN:   if (fin_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_axi_arready = ar_rdy_q;
  assign m_axi_arvalid = (state == ISSUE);
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;
  assign m_axi_arlock  = lock_q;
  assign m_axi_arcache = cache_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_arqos   = qos_q;
  assign m_axi_aruser  = user_q;

  // Stray downstream beats are held off while idle.
  assign m_axi_rready  = active & s_axi_rready;
  assign s_axi_rvalid  = active & m_axi_rvalid;
  assign s_axi_rlast   = active & m_axi_rlast & (r_sub_cnt == n_sub_q - 9'd1);
  assign s_axi_rid     = active ? m_axi_rid   : '0;
  assign s_axi_rdata   = active ? m_axi_rdata : '0;
  assign s_axi_rresp   = active ? m_axi_rresp : '0;
  assign s_axi_ruser   = active ? m_axi_ruser : '0;
endmodule
